// File: rtl/alu_op_sequencer.sv
// Request/response sequencer in front of the combinational ALU: latches one op, waits its settle count, returns Z.
// Optional build macro ALUSEQ_DIVZERO_TRAP_EN rejects DIV with a zero divisor instead of issuing it.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES        = 1,
  parameter int unsigned MULDIV_SETTLE_CYCLES = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic [31:0] iReqA,
  input  logic [31:0] iReqB,
  input  logic [3:0]  iReqCtrl,
  output logic [31:0] oAluA,
  output logic [31:0] oAluB,
  output logic [3:0]  oAluCtrl,
  input  logic [31:0] iAluHi,
  input  logic [31:0] iAluLo,
  input  logic        iAluZero,
  input  logic        iAluNeg,
  output logic        oRespValid,
  input  logic        iRespReady,
  output logic [31:0] oZHi,
  output logic [31:0] oZLo,
  output logic        oZero,
  output logic        oNeg,
  output logic        oErr
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] OP_MUL  = 4'h5;
  localparam logic [CW-1:0] OP_DIV  = 4'h6;
  localparam logic [CW-1:0] OP_LAST = 4'h9;

  localparam logic [CW-1:0] CNT_ALU    = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_MULDIV = CW'(MULDIV_SETTLE_CYCLES);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] alu_a_d, alu_b_d;
  logic [CW-1:0] alu_ctrl_d;
  logic [DW-1:0] z_hi_d, z_lo_d;
  logic          zero_d, neg_d, err_d;
  logic          is_muldiv;
  logic          reject;

  // Handshake flags are decoded from state and forced low while reset is held.
  assign oReqReady  = (state_q == S_IDLE) && !iRst;
  assign oRespValid = (state_q == S_DONE) && !iRst;

  assign is_muldiv = (iReqCtrl == OP_MUL) || (iReqCtrl == OP_DIV);

`ifdef ALUSEQ_DIVZERO_TRAP_EN
  assign reject = (iReqCtrl > OP_LAST) || ((iReqCtrl == OP_DIV) && (iReqB == '0));
`else
  assign reject = (iReqCtrl > OP_LAST);
`endif

  // Next-state and next-register values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = oAluA;
    alu_b_d    = oAluB;
    alu_ctrl_d = oAluCtrl;
    z_hi_d     = oZHi;
    z_lo_d     = oZLo;
    zero_d     = oZero;
    neg_d      = oNeg;
    err_d      = oErr;

    case (state_q)
      S_IDLE: begin
        if (iReqValid) begin
          if (reject) begin
            // Rejected ops leave the ALU operands untouched and answer immediately.
            state_d = S_DONE;
            err_d   = 1'b1;
            z_hi_d  = '0;
            z_lo_d  = '0;
            zero_d  = 1'b0;
            neg_d   = 1'b0;
          end else begin
            state_d    = S_WAIT;
            alu_a_d    = iReqA;
            alu_b_d    = iReqB;
            alu_ctrl_d = iReqCtrl;
            cnt_d      = is_muldiv ? CNT_MULDIV : CNT_ALU;
          end
        end
      end
      S_WAIT: begin
        // <= 1 also covers an out-of-range zero count without wrapping.
        if (cnt_q <= 4'd1) begin
          state_d = S_DONE;
          cnt_d   = '0;
          z_hi_d  = iAluHi;
          z_lo_d  = iAluLo;
          zero_d  = iAluZero;
          neg_d   = iAluNeg;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (iRespReady) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      oAluA    <= '0;
      oAluB    <= '0;
      oAluCtrl <= '0;
      oZHi     <= '0;
      oZLo     <= '0;
      oZero    <= 1'b0;
      oNeg     <= 1'b0;
      oErr     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      oAluA    <= alu_a_d;
      oAluB    <= alu_b_d;
      oAluCtrl <= alu_ctrl_d;
      oZHi     <= z_hi_d;
      oZLo     <= z_lo_d;
      oZero    <= zero_d;
      oNeg     <= neg_d;
      oErr     <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: transaction-level model checked every cycle plus directed literal checks.
module tb_alu_op_sequencer;

  localparam int SC = 1;
  localparam int MC = 4;

  typedef struct packed {
    logic        err;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
    logic        neg;
  } resp_t;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iReqValid;
  logic        oReqReady;
  logic [31:0] iReqA, iReqB;
  logic [3:0]  iReqCtrl;
  logic [31:0] oAluA, oAluB;
  logic [3:0]  oAluCtrl;
  logic [31:0] iAluHi, iAluLo;
  logic        iAluZero, iAluNeg;
  logic        oRespValid;
  logic        iRespReady;
  logic [31:0] oZHi, oZLo;
  logic        oZero, oNeg, oErr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 iClk = ~iClk;

  alu_op_sequencer #(
    .SETTLE_CYCLES        (SC),
    .MULDIV_SETTLE_CYCLES (MC)
  ) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iReqValid  (iReqValid),
    .oReqReady  (oReqReady),
    .iReqA      (iReqA),
    .iReqB      (iReqB),
    .iReqCtrl   (iReqCtrl),
    .oAluA      (oAluA),
    .oAluB      (oAluB),
    .oAluCtrl   (oAluCtrl),
    .iAluHi     (iAluHi),
    .iAluLo     (iAluLo),
    .iAluZero   (iAluZero),
    .iAluNeg    (iAluNeg),
    .oRespValid (oRespValid),
    .iRespReady (iRespReady),
    .oZHi       (oZHi),
    .oZLo       (oZLo),
    .oZero      (oZero),
    .oNeg       (oNeg),
    .oErr       (oErr)
  );

  // Reference ALU: {hi, lo, zero, neg}.
  function automatic logic [65:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    logic [63:0] p;
    logic [31:0] hi, lo;
    hi = '0;
    lo = '0;
    case (c)
      4'h0: lo = a + b;
      4'h1: lo = a - b;
      4'h2: lo = a | b;
      4'h3: lo = a ^ b;
      4'h4: lo = a & b;
      4'h5: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      4'h6: if (b == 32'd0) begin hi = 32'hFFFF_FFFF; lo = a; end
            else begin hi = a / b; lo = a % b; end
      4'h7: lo = a << b[4:0];
      4'h8: lo = a >> b[4:0];
      4'h9: lo = 32'($signed(a) >>> b[4:0]);
      default: ;
    endcase
    return {hi, lo, (hi == 32'd0) && (lo == 32'd0),
            ((c == 4'h5) || (c == 4'h6)) ? hi[31] : lo[31]};
  endfunction

  // Environment ALU driven from the sequencer's registered operands.
  always_comb {iAluHi, iAluLo, iAluZero, iAluNeg} = alu_ref(oAluA, oAluB, oAluCtrl);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Transaction model: busy flag, response deadline, and the Z word visible to the requester.
  initial begin : model
    resp_t       cur, pend, vis;
    logic        busy, started, rej;
    int          resp_at;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_c;
    logic [65:0] r;
    cur = '0; pend = '0; busy = 1'b0; started = 1'b0; resp_at = 0;
    m_a = '0; m_b = '0; m_c = '0;
    forever begin
      @(posedge iClk);
      if (iRst) begin
        started = 1'b1; busy = 1'b0; cur = '0; pend = '0;
        m_a = '0; m_b = '0; m_c = '0;
      end else if (started) begin
        if (!busy) begin
          if (iReqValid) begin
            rej = (iReqCtrl > 4'h9);
`ifdef ALUSEQ_DIVZERO_TRAP_EN
            if ((iReqCtrl == 4'h6) && (iReqB == 32'd0)) rej = 1'b1;
`endif
            busy = 1'b1;
            if (rej) begin
              pend = '0;
              pend.err = 1'b1;
              resp_at = cyc + 1;
            end else begin
              m_a = iReqA; m_b = iReqB; m_c = iReqCtrl;
              r = alu_ref(iReqA, iReqB, iReqCtrl);
              pend.err = 1'b0; pend.hi = r[65:34]; pend.lo = r[33:2];
              pend.zero = r[1]; pend.neg = r[0];
              resp_at = cyc + 1 + (((iReqCtrl == 4'h5) || (iReqCtrl == 4'h6)) ? MC : SC);
            end
          end
        end else if ((cyc >= resp_at) && iRespReady) begin
          busy = 1'b0;
          cur = pend;
        end
      end
      cyc++;
      @(negedge iClk);
      if (started) begin
        vis = (busy && (cyc >= resp_at)) ? pend : cur;
        chk("req_ready",  64'(oReqReady),  64'(!busy && !iRst));
        chk("resp_valid", 64'(oRespValid), 64'(busy && (cyc >= resp_at) && !iRst));
        chk("z_hi",       64'(oZHi),       64'(vis.hi));
        chk("z_lo",       64'(oZLo),       64'(vis.lo));
        chk("zero",       64'(oZero),      64'(vis.zero));
        chk("neg",        64'(oNeg),       64'(vis.neg));
        chk("err",        64'(oErr),       64'(vis.err));
        chk("alu_a",      64'(oAluA),      64'(m_a));
        chk("alu_b",      64'(oAluB),      64'(m_b));
        chk("alu_ctrl",   64'(oAluCtrl),   64'(m_c));
      end
    end
  end

  // One request/response transaction with literal expectations.
  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c, input int exp_lat, input logic [31:0] e_hi,
                       input logic [31:0] e_lo, input logic e_zero, input logic e_neg,
                       input logic e_err, input int hold, input logic early);
    int k;
    k = 0;
    if (early) iRespReady = 1'b1;
    while (!oReqReady && (k < 40)) begin @(posedge iClk); #1; k++; end
    chk({name, "_ready_in"}, 64'(oReqReady), 64'd1);
    iReqA = a; iReqB = b; iReqCtrl = c; iReqValid = 1'b1;
    @(posedge iClk); #1;
    iReqValid = 1'b0;
    k = 1;
    while (!oRespValid && (k < 40)) begin @(posedge iClk); #1; k++; end
    chk({name, "_latency"}, 64'(k), 64'(exp_lat));
    chk({name, "_hi"},   64'(oZHi),  64'(e_hi));
    chk({name, "_lo"},   64'(oZLo),  64'(e_lo));
    chk({name, "_zero"}, 64'(oZero), 64'(e_zero));
    chk({name, "_neg"},  64'(oNeg),  64'(e_neg));
    chk({name, "_err"},  64'(oErr),  64'(e_err));
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        iReqValid = 1'b1; iReqA = 32'h5555_5555; iReqB = 32'h1; iReqCtrl = 4'h0;
        @(posedge iClk); #1;
        chk({name, "_bp_ready"}, 64'(oReqReady), 64'd0);
        chk({name, "_bp_lo"},    64'(oZLo),      64'(e_lo));
        chk({name, "_bp_err"},   64'(oErr),      64'(e_err));
      end
      iReqValid = 1'b0;
      iRespReady = 1'b1;
    end
    @(posedge iClk); #1;
    iRespReady = 1'b0;
    chk({name, "_ready_out"}, 64'(oReqReady), 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    iRst = 1'b1; iReqValid = 1'b0; iReqA = '0; iReqB = '0; iReqCtrl = '0; iRespReady = 1'b0;
    @(posedge iClk); @(posedge iClk); #1;
    chk("rst_ready_held", 64'(oReqReady),  64'd0);
    chk("rst_valid_held", 64'(oRespValid), 64'd0);
    iRst = 1'b0;
    #1;
    chk("rst_ready_rel", 64'(oReqReady), 64'd1);
    chk("rst_zlo",       64'(oZLo),      64'd0);
    chk("rst_alu_a",     64'(oAluA),     64'd0);
    chk("rst_err",       64'(oErr),      64'd0);
    @(posedge iClk); #1;

    do_op("add",   32'd5, 32'd7, 4'h0, 2, 32'd0, 32'd12, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    do_op("sub",   32'd3, 32'd5, 4'h1, 2, 32'd0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    do_op("subz",  32'd9, 32'd9, 4'h1, 2, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    do_op("mul",   32'h0001_0000, 32'h0001_0000, 4'h5, 5, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    do_op("div",   32'd7, 32'd2, 4'h6, 5, 32'd3, 32'd1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    do_op("ill",   32'h1234, 32'h5678, 4'hC, 1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    chk("ill_alu_ctrl", 64'(oAluCtrl), 64'h6);
    chk("ill_alu_a",    64'(oAluA),    64'd7);
`ifdef ALUSEQ_DIVZERO_TRAP_EN
    do_op("div0",  32'd9, 32'd0, 4'h6, 1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    chk("div0_alu_b", 64'(oAluB), 64'd2);
`else
    do_op("div0",  32'd9, 32'd0, 4'h6, 5, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b1, 1'b0, 0, 1'b0);
`endif
    do_op("xor_bp", 32'h0000_F0F0, 32'h0000_FF00, 4'h3, 2, 32'd0, 32'h0000_0FF0, 1'b0, 1'b0, 1'b0, 10, 1'b0);
    do_op("sra",   32'h8000_0000, 32'd4, 4'h9, 2, 32'd0, 32'hF800_0000, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    do_op("sll",   32'd1, 32'd31, 4'h7, 2, 32'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    do_op("srl",   32'h8000_0000, 32'd31, 4'h8, 2, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    do_op("or0",   32'd0, 32'd0, 4'h2, 2, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    do_op("and",   32'hFF00_FF00, 32'h0FF0_0FF0, 4'h4, 2, 32'd0, 32'h0F00_0F00, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    do_op("mulbig", 32'hFFFF_FFFF, 32'd2, 4'h5, 5, 32'd1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Reset in the middle of a MUL settle window drops it.
    iReqA = 32'd3; iReqB = 32'd4; iReqCtrl = 4'h5; iReqValid = 1'b1;
    @(posedge iClk); #1;
    iReqValid = 1'b0;
    @(posedge iClk); #1;
    iRst = 1'b1;
    #1;
    chk("mrst_ready_held", 64'(oReqReady),  64'd0);
    chk("mrst_valid_held", 64'(oRespValid), 64'd0);
    @(posedge iClk); #1;
    iRst = 1'b0;
    #1;
    chk("mrst_ready", 64'(oReqReady), 64'd1);
    chk("mrst_valid", 64'(oRespValid), 64'd0);
    chk("mrst_zhi",   64'(oZHi),      64'd0);
    chk("mrst_zlo",   64'(oZLo),      64'd0);
    chk("mrst_alu_a", 64'(oAluA),     64'd0);
    chk("mrst_ctrl",  64'(oAluCtrl),  64'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge iClk); #1;
      chk("mrst_no_resp", 64'(oRespValid), 64'd0);
    end
    do_op("post_rst", 32'd100, 32'd23, 4'h0, 2, 32'd0, 32'd123, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    repeat (3) @(posedge iClk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
